// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the two requesters, the memory slave port and the dmem_arbiter.
// Handshake: a requester holds req+payload until its one-cycle gnt; the slave takes o_s_vld when i_s_rdy=1 in that cycle and answers a read with a one-cycle i_s_rvld.
interface dmem_arbiter_if;
  logic        i_m0_req;
  logic        i_m0_wren;
  logic [31:0] i_m0_addr;
  logic [31:0] i_m0_wdata;
  logic        o_m0_gnt;
  logic        o_m0_rvld;
  logic [31:0] o_m0_rdata;

  logic        i_m1_req;
  logic        i_m1_wren;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m1_wdata;
  logic        o_m1_gnt;
  logic        o_m1_rvld;
  logic [31:0] o_m1_rdata;

  logic        o_s_vld;
  logic        o_s_wren;
  logic [31:0] o_s_addr;
  logic [31:0] o_s_wdata;
  logic        i_s_rdy;
  logic        i_s_rvld;
  logic [31:0] i_s_rdata;

  logic        o_err;
  logic [1:0]  o_dbg_state;

  modport slave (
    input  i_m0_req, i_m0_wren, i_m0_addr, i_m0_wdata,
    input  i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata,
    input  i_s_rdy, i_s_rvld, i_s_rdata,
    output o_m0_gnt, o_m0_rvld, o_m0_rdata,
    output o_m1_gnt, o_m1_rvld, o_m1_rdata,
    output o_s_vld, o_s_wren, o_s_addr, o_s_wdata,
    output o_err, o_dbg_state
  );

  modport master (
    output i_m0_req, i_m0_wren, i_m0_addr, i_m0_wdata,
    output i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata,
    output i_s_rdy, i_s_rvld, i_s_rdata,
    input  o_m0_gnt, o_m0_rvld, o_m0_rdata,
    input  o_m1_gnt, o_m1_rvld, o_m1_rdata,
    input  o_s_vld, o_s_wren, o_s_addr, o_s_wdata,
    input  o_err, o_dbg_state
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter, one transaction in flight, read timeout with 0xDEADBEEF abort data.
// Define ARB_RR_EN for round-robin on contention; without it port 0 has fixed priority.
module dmem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_VAL  = CW'(TIMEOUT_CYCLES);
  localparam logic [31:0]   TMO_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          wren_q, wren_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel;
  logic          rvld_p;
  logic [31:0]   rdata_p;

`ifdef ARB_RR_EN
  logic last_q, last_d;

  // On contention grant the port that was not granted last; a lone request wins outright.
  always_comb sel = (bus.i_m0_req && bus.i_m1_req) ? ~last_q : bus.i_m1_req;

  always_comb begin
    last_d = last_q;
    if (state_q == ST_ISSUE && bus.i_s_rdy) last_d = owner_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`else
  always_comb sel = ~bus.i_m0_req;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    wren_d          = wren_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    cnt_d           = cnt_q;
    rvld_p          = 1'b0;
    rdata_p         = '0;
    bus.o_m0_gnt    = 1'b0;
    bus.o_m1_gnt    = 1'b0;
    bus.o_s_vld     = 1'b0;
    bus.o_s_wren    = 1'b0;
    bus.o_s_addr    = '0;
    bus.o_s_wdata   = '0;
    bus.o_err       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_m0_req || bus.i_m1_req) begin
          owner_d = sel;
          wren_d  = sel ? bus.i_m1_wren  : bus.i_m0_wren;
          addr_d  = sel ? bus.i_m1_addr  : bus.i_m0_addr;
          wdata_d = sel ? bus.i_m1_wdata : bus.i_m0_wdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.o_s_vld   = 1'b1;
        bus.o_s_wren  = wren_q;
        bus.o_s_addr  = addr_q;
        bus.o_s_wdata = wdata_q;
        if (bus.i_s_rdy) begin
          bus.o_m0_gnt = ~owner_q;
          bus.o_m1_gnt = owner_q;
          cnt_d        = '0;
          state_d      = wren_q ? ST_IDLE : ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        // Real slave data beats a timeout landing in the same cycle.
        if (bus.i_s_rvld) begin
          rvld_p  = 1'b1;
          rdata_p = bus.i_s_rdata;
          state_d = ST_IDLE;
        end else if (cnt_q == TMO_VAL) begin
          rvld_p    = 1'b1;
          rdata_p   = TMO_DATA;
          bus.o_err = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    bus.o_m0_rvld  = rvld_p & ~owner_q;
    bus.o_m1_rvld  = rvld_p & owner_q;
    bus.o_m0_rdata = (rvld_p & ~owner_q) ? rdata_p : '0;
    bus.o_m1_rdata = (rvld_p & owner_q)  ? rdata_p : '0;
  end

  assign bus.o_dbg_state = state_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a transaction-level model predicts owner, slave payload, gnt cycle and read result.
// Timeout model: the read aborts in WAIT_RD cycle index TMO (0-based) unless slave data arrived at or before it.
module tb_dmem_arbiter;
  localparam int          TMO      = 16;
  localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          grant_log[$];
  int          model_last = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input bit e_svld, input bit e_wren,
                             input logic [31:0] e_addr, input logic [31:0] e_wdata,
                             input bit e_g0, input bit e_g1, input bit e_v0, input bit e_v1,
                             input logic [31:0] e_rd0, input logic [31:0] e_rd1, input bit e_err);
    chk($sformatf("%s.s_vld", tag),   32'(bus.o_s_vld),   32'(e_svld));
    chk($sformatf("%s.s_wren", tag),  32'(bus.o_s_wren),  32'(e_wren));
    chk($sformatf("%s.s_addr", tag),  bus.o_s_addr,       e_addr);
    chk($sformatf("%s.s_wdata", tag), bus.o_s_wdata,      e_wdata);
    chk($sformatf("%s.m0_gnt", tag),  32'(bus.o_m0_gnt),  32'(e_g0));
    chk($sformatf("%s.m1_gnt", tag),  32'(bus.o_m1_gnt),  32'(e_g1));
    chk($sformatf("%s.m0_rvld", tag), 32'(bus.o_m0_rvld), 32'(e_v0));
    chk($sformatf("%s.m1_rvld", tag), 32'(bus.o_m1_rvld), 32'(e_v1));
    chk($sformatf("%s.m0_rdata", tag), bus.o_m0_rdata,    e_rd0);
    chk($sformatf("%s.m1_rdata", tag), bus.o_m1_rdata,    e_rd1);
    chk($sformatf("%s.err", tag),     32'(bus.o_err),     32'(e_err));
  endtask

  task automatic check_idle(input string tag);
    check_cycle(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  function automatic int model_pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef ARB_RR_EN
      return (model_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  // One transaction from request to completion; abort_k >= 0 pulls reset in that WAIT_RD cycle.
  task automatic do_txn(input bit r0, input bit r1, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int rdy_dly, input int rd_lat, input logic [31:0] rdat,
                        input bit late, input int abort_k);
    int          w;
    logic [31:0] a1, d1, ea, ed, e;
    bit          terr;
    w  = model_pick(r0, r1);
    a1 = r0 ? (addr ^ 32'h0000_0100) : addr;
    d1 = r0 ? ~wdata : wdata;
    ea = (w == 1) ? a1 : addr;
    ed = (w == 1) ? d1 : wdata;

    @(negedge clk);
    bus.i_m0_req   = r0;
    bus.i_m0_wren  = r0 ? wr : 1'($urandom_range(0, 1));
    bus.i_m0_addr  = r0 ? addr : $urandom;
    bus.i_m0_wdata = r0 ? wdata : $urandom;
    bus.i_m1_req   = r1;
    bus.i_m1_wren  = r1 ? wr : 1'($urandom_range(0, 1));
    bus.i_m1_addr  = r1 ? a1 : $urandom;
    bus.i_m1_wdata = r1 ? d1 : $urandom;
    bus.i_s_rdy    = 1'($urandom_range(0, 1));
    bus.i_s_rvld   = 1'($urandom_range(0, 1));
    bus.i_s_rdata  = $urandom;
    #1 check_idle("req");

    for (int c = 0; c <= rdy_dly; c++) begin
      @(negedge clk);
      bus.i_s_rdy   = (c == rdy_dly);
      bus.i_s_rvld  = 1'($urandom_range(0, 1));
      bus.i_s_rdata = $urandom;
      #1;
      check_cycle("issue", 1'b1, wr, ea, ed, (c == rdy_dly) && (w == 0), (c == rdy_dly) && (w == 1),
                  1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    end
    grant_log.push_back(w);
    model_last = w;
    bus.i_m0_req   = 1'b0;
    bus.i_m1_req   = 1'b0;
    bus.i_m0_addr  = $urandom;
    bus.i_m1_addr  = $urandom;
    bus.i_m0_wdata = $urandom;
    bus.i_m1_wdata = $urandom;

    if (!wr) begin
      exp_q.push_back((rd_lat <= TMO) ? rdat : TMO_DATA);
      for (int k = 0; k <= TMO; k++) begin
        @(negedge clk);
        bus.i_s_rdy   = 1'($urandom_range(0, 1));
        bus.i_s_rvld  = (k == rd_lat);
        bus.i_s_rdata = (k == rd_lat) ? rdat : $urandom;
        if (k == abort_k) begin
          bus.i_s_rvld = 1'b1;
          #2 rst_n = 1'b0;
          #1 check_idle("rst_abort");
          exp_q.delete();
          model_last = 1;
          @(negedge clk);
          bus.i_s_rvld = 1'b0;
          #1 check_idle("rst_hold");
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        #1;
        if (k == rd_lat || k == TMO) begin
          terr = (rd_lat > TMO);
          if (exp_q.size() == 0) begin
            chk("exp_q_underflow", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            check_cycle("rdone", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, w == 0, w == 1,
                        (w == 0) ? e : 32'h0, (w == 1) ? e : 32'h0, terr);
          end
          break;
        end
        check_idle("wait");
      end
    end

    if (late) begin
      @(negedge clk);
      bus.i_s_rvld  = 1'b1;
      bus.i_s_rdata = $urandom;
      bus.i_s_rdy   = 1'($urandom_range(0, 1));
      #1 check_idle("late");
      bus.i_s_rvld  = 1'b0;
    end
  endtask

  initial begin
    int exp_w;
    int r;
    bus.i_m0_req = 1'b0; bus.i_m0_wren = 1'b0; bus.i_m0_addr = '0; bus.i_m0_wdata = '0;
    bus.i_m1_req = 1'b0; bus.i_m1_wren = 1'b0; bus.i_m1_addr = '0; bus.i_m1_wdata = '0;
    bus.i_s_rdy  = 1'b0; bus.i_s_rvld  = 1'b0; bus.i_s_rdata = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_m0_req = 1'b1;
    bus.i_s_rdy  = 1'b1;
    bus.i_s_rvld = 1'b1;
    #1 check_idle("reset");
    bus.i_m0_req = 1'b0;
    bus.i_s_rdy  = 1'b0;
    bus.i_s_rvld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_txn(1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 0, 0, 32'h0, 1'b0, -1);
    do_txn(1'b0, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 0, 2, 32'hCAFE_0001, 1'b0, -1);

    grant_log.delete();
    repeat (4) do_txn(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom,
                      $urandom_range(0, 2), $urandom_range(0, 4), $urandom, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      exp_w = i % 2;
`else
      exp_w = 0;
`endif
      chk($sformatf("contend%0d", i), grant_log[i], exp_w);
    end

    do_txn(1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'hA5A5_5A5A, 5, 0, 32'h0, 1'b0, -1);
    do_txn(1'b0, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 1, 1000, 32'h0, 1'b1, -1);
    do_txn(1'b1, 1'b0, 1'b0, 32'h0000_5000, 32'h0, 0, TMO, 32'h1357_9BDF, 1'b0, -1);
    do_txn(1'b1, 1'b0, 1'b0, 32'h0000_6000, 32'h0, 0, 100, 32'h0, 1'b0, 3);
    do_txn(1'b0, 1'b1, 1'b1, 32'h0000_8000, 32'h0000_FEED, 0, 0, 32'h0, 1'b0, -1);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(1, 3);
      do_txn(r[0], r[1], 1'($urandom_range(0, 1)), $urandom, $urandom,
             $urandom_range(0, 4), $urandom_range(0, 20), $urandom,
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1);
    end

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
